// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the
// inverse-cipher datapath.
package aes_pkg;

    localparam int BLOCK_LENGTH = 128;
    localparam int NR           = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

    // Byte 0 of the table sits in the top byte of the vector.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Bit index of byte b's MSB is 2047-8b == {~b, 3'b111}.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul_0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul_0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul_0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage

// File: rtl/aes_dec_iter_if.sv
// Block handshake and key-store port bundle of the iterative AES decryptor.
// slave = core side, master = producer/consumer/key-store side.
interface aes_dec_iter_if;
    import aes_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [BLOCK_LENGTH-1:0] IN;
    logic [3:0]              rk_idx;
    logic [BLOCK_LENGTH-1:0] RK;
    logic [BLOCK_LENGTH-1:0] OUT;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_valid, IN, RK, out_ready,
        output in_ready, rk_idx, OUT, out_valid
    );

    modport master (
        output in_valid, IN, RK, out_ready,
        input  in_ready, rk_idx, OUT, out_valid
    );

endinterface

// File: rtl/inv_round.sv
// One combinational inverse-cipher round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless last_i is set.
module inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_LENGTH-1:0] state_i,
    input  logic [BLOCK_LENGTH-1:0] rk_i,
    input  logic                    last_i,
    output logic [BLOCK_LENGTH-1:0] state_o
);

    logic [BLOCK_LENGTH-1:0] isr;
    logic [BLOCK_LENGTH-1:0] ark;
    logic [BLOCK_LENGTH-1:0] mix;
    logic [7:0]              a0, a1, a2, a3;

    always_comb begin
        isr = '0;
        mix = '0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        // Row r rotates right by r: out(r,c) takes in(r,(c-r) mod 4).
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127-8*(r+4*c) -: 8] =
                    inv_sbox(state_i[127-8*(r+4*((c+4-r)%4)) -: 8]);
            end
        end
        ark = isr ^ rk_i;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127-32*c -: 8];
            a1 = ark[119-32*c -: 8];
            a2 = ark[111-32*c -: 8];
            a3 = ark[103-32*c -: 8];
            mix[127-32*c -: 32] = {
                gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
                gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
                gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
                gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)
            };
        end
        state_o = last_i ? ark : mix;
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock.
// Optional AES_DEC_ZEROIZE_EN hides and clears the result once consumed.
module aes_dec_iter
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    aes_dec_iter_if.slave bus
);

    fsm_e                    fsm_q, fsm_d;
    logic [BLOCK_LENGTH-1:0] state_q, state_d;
    logic [3:0]              round_q, round_d;
    logic [BLOCK_LENGTH-1:0] rnd_out;
    logic                    last;
    logic                    accept;
    logic                    in_rdy;
    logic                    out_vld;
    logic [3:0]              rk_sel;

    inv_round u_inv_round (
        .state_i (state_q),
        .rk_i    (bus.RK),
        .last_i  (last),
        .state_o (rnd_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        last    = 1'b0;
        accept  = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        rk_sel  = 4'd10;
        unique case (fsm_q)
            IDLE: begin
                in_rdy = 1'b1;
                accept = bus.in_valid;
            end
            ROUND: begin
                rk_sel  = round_q;
                state_d = rnd_out;
                round_d = round_q - 4'd1;
                if (round_q == 4'd1) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                rk_sel  = 4'd0;
                last    = 1'b1;
                state_d = rnd_out;
                fsm_d   = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                in_rdy  = bus.out_ready;
                if (bus.out_ready) begin
                    fsm_d  = IDLE;
                    accept = bus.in_valid;
`ifdef AES_DEC_ZEROIZE_EN
                    state_d = '0;
`endif
                end
            end
            default: ;
        endcase
        // A fresh block always wins, including the back-to-back DONE case.
        if (accept) begin
            state_d = bus.IN ^ bus.RK;
            round_d = 4'd9;
            fsm_d   = ROUND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.rk_idx    = rk_sel;
`ifdef AES_DEC_ZEROIZE_EN
    assign bus.OUT = out_vld ? state_q : '0;
`else
    assign bus.OUT = state_q;
`endif

endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative AES-128 decryption core. It is the inverse-cipher counterpart of the pipelined encryption datapath. It accepts one 128-bit ciphertext block over a valid/ready handshake and applies the FIPS-197 inverse cipher one round per clock, starting at round key 10 and finishing at round key 0. It then holds the plaintext until the consumer accepts it. Round keys come from an external key store that the core indexes directly, so the same store can serve the encryption path.

## Interface
- BLOCK_LENGTH, 128, data/key width; only 128 supported.
- NR, 10, number of rounds; only 10 supported.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ciphertext on IN is valid.
- in_ready  out  1  core can accept a block this cycle.
- IN  in  128  ciphertext; bit 127 = byte 0 (FIPS-197 order).
- rk_idx  out  4  round-key index requested, 0..10.
- RK  in  128  round key for rk_idx, combinational same-cycle return.
- OUT  out  128  plaintext, same byte order as IN.
- out_valid  out  1  OUT holds a completed plaintext.
- out_ready  in  1  consumer accepts OUT this cycle.

## Operation
- FSM states:
  - IDLE: in_ready=1, rk_idx=10. On in_valid, state_q ← IN ^ RK, round_q ← 9, go to ROUND.
  - ROUND: rk_idx=round_q. state_q ← InvMixColumns(InvSubBytes(InvShiftRows(state_q)) ^ RK). round_q decrements. When round_q==1, go to FINAL.
  - FINAL: rk_idx=0. state_q ← InvSubBytes(InvShiftRows(state_q)) ^ RK. Go to DONE.
  - DONE: out_valid=1, OUT=state_q, rk_idx=10. On out_ready, go to IDLE.
- in_ready = IDLE | (DONE & out_ready). When DONE & out_ready & in_valid, the new block is loaded exactly as in IDLE and the FSM goes directly to ROUND. The old result is consumed in the same cycle.
- IN and RK are sampled only on the edges defined above. IN may change freely outside the accept cycle.
- in_valid in ROUND/FINAL is ignored (in_ready=0). The producer must hold in_valid.
- out_ready outside DONE is ignored.
- round_q is 4 bits and never wraps; it is only meaningful in ROUND/FINAL.
- Reset at any time aborts the block in flight; no partial result is emitted.
- Reset values: state IDLE, state_q=0, round_q=0, OUT=0, out_valid=0, in_ready=1, rk_idx=10.

## Timing
- Accept edge = cycle 0 (the AddRoundKey with RK10 is applied there).
- Rounds 9..1 take edges 1..9. Round 0 takes edge 10. out_valid rises after edge 10.
- Latency: 10 cycles from the accept edge to out_valid.
- Throughput: one block per 11 cycles with out_ready held high. The back-to-back accept in DONE removes the IDLE bubble.
- rk_idx is a registered-state decode (glitch-free per cycle). RK must settle within the same cycle.
- OUT and out_valid are driven from registers or FSM state only. There is no combinational path from IN or RK to OUT.

## Configuration
- AES_DEC_ZEROIZE_EN
  - Defined: state_q is cleared to 0 on the edge that leaves DONE without a new accept. OUT is forced to 0 whenever out_valid=0.
  - Undefined: OUT = state_q at all times, so the last plaintext (or intermediate round state) stays visible on OUT.
- Timing and the handshake are identical in both builds.

## Structure
- Shared package aes_pkg:
  - BLOCK_LENGTH and NR constants.
  - State enum: IDLE, ROUND, FINAL, DONE.
  - Inverse S-box function inv_sbox(byte).
  - gf_mul helpers for {09}, {0b}, {0d} and {0e}.
- Sub-module inv_round (combinational):
  - Computes InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns.
  - Input `last` bypasses InvMixColumns.
  - Instantiated once; the FSM selects `last` in FINAL.

## Test plan
- FIPS-197 C.1 vector (key 000102030405060708090a0b0c0d0e0f, bench supplies expanded round keys by rk_idx):
  - Stimulus: IN=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: OUT=00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after the accept.
- FIPS-197 Appendix B vector (key 2b7e151628aed2a6abf7158809cf4f3c):
  - Stimulus: IN=3925841d02dc09fbdc118597196a0b32.
  - Required: OUT=3243f6a8885a308d313198a2e0370734.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required: OUT stable, in_ready=0. Then out_ready=1 and in_valid=1 in the same cycle → the next block is accepted in that cycle and its result appears 10 cycles later.
- rk_idx sequence:
  - Required: 10,9,8,…,1,0 on consecutive cycles starting at the accept cycle.
  - Required: in_valid toggled during ROUND has no effect.
- Reset mid-operation:
  - Stimulus: assert rst at round 5.
  - Required: out_valid=0 and OUT=0 immediately. After release, the C.1 vector decrypts correctly.
- Zeroize build (AES_DEC_ZEROIZE_EN defined):
  - Required: OUT=0 on every cycle with out_valid=0.
  - Required: without the macro, OUT still shows the last plaintext after the handshake.
